// File: rtl/credit_sender.sv
// Transmit side of a credit-based channel: forwards upstream words as enqueue strobes
// into a receiver FIFO that has no full flag, and tracks free receiver slots with credits.
//
// state   | meaning
// S_RUN   | credits available, accepting words
// S_EMPTY | no credits left, waiting for a credit return
// S_ERR   | a credit arrived while already at CMAX; sticky until reset
module credit_sender #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_ADDR  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_enq,
  input  logic                         i_credit,
  output logic [FIFO_ADDR:0]           o_credits,
  output logic                         o_credit_err
);

  localparam int CW = FIFO_ADDR + 1;
  localparam logic [CW-1:0] CMAX = CW'(2 ** FIFO_ADDR);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_EMPTY = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                credits_q, credits_d;
  logic                         enq_q, enq_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         fire;

  // Ready depends only on registered state so upstream never sees a combinational loop.
  assign o_ready      = (state_q == S_RUN) && (credits_q != '0);
  assign fire         = i_valid && o_ready;
  assign o_data       = data_q;
  assign o_enq        = enq_q;
  assign o_credits    = credits_q;
  assign o_credit_err = (state_q == S_ERR);

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    enq_d     = fire;
    data_d    = fire ? i_data : data_q;
    case (state_q)
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        if (i_credit && !fire && (credits_q == CMAX)) begin
          state_d = S_ERR;
        end else begin
          if (fire && !i_credit) begin
            credits_d = credits_q - 1'b1;
          end else if (!fire && i_credit) begin
            credits_d = credits_q + 1'b1;
          end
          state_d = (credits_d == '0) ? S_EMPTY : S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_RUN;
      credits_q <= CMAX;
      enq_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      enq_q     <= enq_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_credit_sender.sv
// Directed and randomised checks of credit_sender against a 4-deep receiver FIFO model.
module tb_credit_sender;

  logic               clock;
  logic               reset;
  logic signed [15:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic signed [15:0] o_data;
  logic               o_enq;
  logic               i_credit;
  logic [2:0]         o_credits;
  logic               o_credit_err;

  int n_tests = 0;
  int n_fail  = 0;

  credit_sender #(.DATA_WIDTH(16), .FIFO_ADDR(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_enq       (o_enq),
    .i_credit    (i_credit),
    .o_credits   (o_credits),
    .o_credit_err(o_credit_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int rx[$];
  int model_cred;
  int wr_val;
  int exp_rd;
  int popped;
  bit deq;
  bit fire;

  initial begin
    reset    = 1'b1;
    i_valid  = 1'b0;
    i_credit = 1'b0;
    i_data   = '0;

    // 1: reset state, then stream until credits run out
    cyc();
    cyc();
    chk("rst_enq", int'(o_enq), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_credits", int'(o_credits), 4);
    chk("rst_err", int'(o_credit_err), 0);
    chk("rst_ready", int'(o_ready), 1);
    reset   = 1'b0;
    i_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_data = 16'(k);
      chk("t1_ready_pre", int'(o_ready), 1);
      cyc();
      chk("t1_enq", int'(o_enq), 1);
      chk("t1_data", int'(o_data), k);
      chk("t1_credits", int'(o_credits), 4 - k);
    end
    chk("t1_ready_empty", int'(o_ready), 0);
    i_data = 16'd5;
    cyc();
    chk("t1_noenq", int'(o_enq), 0);
    chk("t1_data_hold", int'(o_data), 4);
    chk("t1_credits_zero", int'(o_credits), 0);
    chk("t1_ready_still0", int'(o_ready), 0);

    // 2: credit return in S_EMPTY with i_valid held; word accepted a cycle later
    i_credit = 1'b1;
    cyc();
    i_credit = 1'b0;
    chk("t2_ready_rise", int'(o_ready), 1);
    chk("t2_credits_one", int'(o_credits), 1);
    chk("t2_noenq", int'(o_enq), 0);
    cyc();
    chk("t2_enq", int'(o_enq), 1);
    chk("t2_data", int'(o_data), 5);
    chk("t2_credits_zero", int'(o_credits), 0);
    chk("t2_ready_fall", int'(o_ready), 0);

    // 3: at credits=2, simultaneous fire and credit keeps the count flat
    i_valid  = 1'b0;
    i_credit = 1'b1;
    cyc();
    cyc();
    chk("t3_credits_two", int'(o_credits), 2);
    i_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      i_data = 16'(100 + j);
      cyc();
      chk("t3_enq", int'(o_enq), 1);
      chk("t3_data", int'(o_data), 100 + j);
      chk("t3_credits", int'(o_credits), 2);
    end
    i_valid  = 1'b0;
    i_credit = 1'b0;
    cyc();
    chk("t3_enq_off", int'(o_enq), 0);
    chk("t3_credits_end", int'(o_credits), 2);

    // 4: credit at CMAX is an overflow; error is sticky
    reset = 1'b1;
    cyc();
    reset    = 1'b0;
    i_credit = 1'b1;
    cyc();
    i_credit = 1'b0;
    chk("t4_err", int'(o_credit_err), 1);
    chk("t4_ready", int'(o_ready), 0);
    chk("t4_credits", int'(o_credits), 4);
    i_credit = 1'b1;
    i_valid  = 1'b1;
    i_data   = 16'd77;
    cyc();
    cyc();
    cyc();
    chk("t4_err_sticky", int'(o_credit_err), 1);
    chk("t4_ready_sticky", int'(o_ready), 0);
    chk("t4_credits_sat", int'(o_credits), 4);
    chk("t4_noenq", int'(o_enq), 0);

    // 5: reset mid-stream overrides valid and credit
    reset    = 1'b1;
    i_credit = 1'b0;
    i_valid  = 1'b0;
    cyc();
    reset   = 1'b0;
    i_valid = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("t5_credits_one", int'(o_credits), 1);
    reset    = 1'b1;
    i_credit = 1'b1;
    cyc();
    reset    = 1'b0;
    i_valid  = 1'b0;
    i_credit = 1'b0;
    chk("t5_enq", int'(o_enq), 0);
    chk("t5_credits", int'(o_credits), 4);
    chk("t5_err", int'(o_credit_err), 0);
    chk("t5_ready", int'(o_ready), 1);
    chk("t5_data", int'(o_data), 0);

    // 6: random traffic against the receiver FIFO model
    model_cred = 4;
    wr_val     = 1;
    exp_rd     = 1;
    for (int c = 0; c < 400; c++) begin
      if (o_enq) rx.push_back(int'(o_data));
      chk("t6_no_overflow", int'(rx.size() <= 4), 1);
      chk("t6_credits", int'(o_credits), model_cred);
      chk("t6_invariant", int'(o_credits) + rx.size(), 4);
      chk("t6_err", int'(o_credit_err), 0);
      chk("t6_ready", int'(o_ready), int'(model_cred != 0));
      deq = (rx.size() > 0) && ($urandom_range(0, 1) == 1);
      if (deq) begin
        popped = rx.pop_front();
        chk("t6_order", popped, exp_rd);
        exp_rd++;
      end
      i_credit = deq;
      i_valid  = ($urandom_range(0, 2) != 0);
      i_data   = 16'(wr_val);
      fire     = i_valid && (model_cred != 0);
      if (fire) wr_val++;
      if (fire && !deq) model_cred--;
      else if (!fire && deq) model_cred++;
      cyc();
    end
    i_valid  = 1'b0;
    i_credit = 1'b0;
    chk("t6_progress", int'(exp_rd > 50), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
